// File: rtl/snn_frame_ctrl.sv
// Frame sequencer for the snn_rgb datapath: issues raster timing for a
// programmed number of frames, then drains and counts returned pixels.
module snn_frame_ctrl #(
  parameter int unsigned H_RES          = 640,
  parameter int unsigned V_RES          = 480,
  parameter int unsigned H_BLANK        = 100,
  parameter int unsigned V_BLANK        = 10,
  parameter int unsigned PIPELINE_DELAY = 76
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [7:0]  num_frames,
  output logic        busy,
  output logic        done,
  output logic        timeout,
  output logic        spurious,
  output logic        vs_in,
  output logic        hs_in,
  output logic        de_in,
  output logic [9:0]  x_cnt,
  output logic [9:0]  y_cnt,
  input  logic        de_ret,
  output logic        frame_out_done,
  output logic [27:0] ret_count
);

  localparam int unsigned H_TOT     = H_RES + H_BLANK;
  localparam int unsigned V_TOT     = V_RES + V_BLANK;
  localparam int unsigned FRAME_PIX = H_RES * V_RES;
  localparam int unsigned DRAIN_LIM = 4 * PIPELINE_DELAY;
  localparam int unsigned PW        = $clog2(FRAME_PIX + 1);
  localparam int unsigned DW        = $clog2(DRAIN_LIM + 1);

  typedef enum logic [1:0] {ST_IDLE, ST_ACTIVE, ST_DRAIN, ST_DONE} state_t;

  state_t        state_q, state_d;
  logic [7:0]    frames_q, frames_d;
  logic [7:0]    frame_cnt_q, frame_cnt_d;
  logic [9:0]    x_q, x_d, y_q, y_d;
  logic [DW-1:0] drain_q, drain_d;
  logic [27:0]   ret_q, ret_d;
  logic [PW-1:0] pix_q, pix_d;
  logic          hit_q, hit_d;
  logic          fod_q, fod_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          timeout_q, timeout_d;
  logic          spurious_q, spurious_d;
  logic          vs_q, vs_d, hs_q, hs_d, de_q, de_d;
  logic [27:0]   target;
  logic          in_act;

  assign target = 28'(frames_q) * 28'(FRAME_PIX);

  always_comb begin
    state_d     = state_q;
    frames_d    = frames_q;
    frame_cnt_d = frame_cnt_q;
    x_d         = x_q;
    y_d         = y_q;
    drain_d     = drain_q;
    ret_d       = ret_q;
    pix_d       = pix_q;
    hit_d       = 1'b0;
    fod_d       = hit_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    timeout_d   = timeout_q;
    spurious_d  = spurious_q;

    // Returned pixels are counted before the drain exit decision so a
    // final pixel arriving on the limit cycle still gives a normal exit.
    if (de_ret && (state_q == ST_ACTIVE || state_q == ST_DRAIN) && ret_q != '1) begin
      ret_d = ret_q + 28'd1;
      if (pix_q == PW'(FRAME_PIX - 1)) begin
        pix_d = '0;
        hit_d = 1'b1;
      end else begin
        pix_d = pix_q + PW'(1);
      end
    end

    case (state_q)
      ST_IDLE: begin
        busy_d = 1'b0;
        if (de_ret) spurious_d = 1'b1;
        if (start) begin
          timeout_d  = 1'b0;
          spurious_d = 1'b0;
          if (num_frames != 8'd0) begin
            state_d     = ST_ACTIVE;
            busy_d      = 1'b1;
            frames_d    = num_frames;
            frame_cnt_d = '0;
            x_d         = '0;
            y_d         = '0;
            ret_d       = '0;
            pix_d       = '0;
          end else begin
            state_d = ST_DONE;
            done_d  = 1'b1;
          end
        end
      end
      ST_ACTIVE: begin
        if (x_q == 10'(H_TOT - 1)) begin
          x_d = '0;
          if (y_q == 10'(V_TOT - 1)) begin
            y_d = '0;
            if (frame_cnt_q == frames_q - 8'd1) begin
              state_d = ST_DRAIN;
              drain_d = '0;
            end else begin
              frame_cnt_d = frame_cnt_q + 8'd1;
            end
          end else begin
            y_d = y_q + 10'd1;
          end
        end else begin
          x_d = x_q + 10'd1;
        end
      end
      ST_DRAIN: begin
        drain_d = drain_q + DW'(1);
        if (ret_d == target) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
          busy_d  = 1'b0;
        end else if (drain_d == DW'(DRAIN_LIM)) begin
          state_d   = ST_DONE;
          done_d    = 1'b1;
          busy_d    = 1'b0;
          timeout_d = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    in_act = (state_d == ST_ACTIVE);
    vs_d   = in_act && (y_d == 10'd0);
    hs_d   = in_act && (x_d < 10'(H_RES));
    de_d   = in_act && (x_d < 10'(H_RES)) && (y_d < 10'(V_RES));
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      frames_q    <= '0;
      frame_cnt_q <= '0;
      x_q         <= '0;
      y_q         <= '0;
      drain_q     <= '0;
      ret_q       <= '0;
      pix_q       <= '0;
      hit_q       <= 1'b0;
      fod_q       <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      timeout_q   <= 1'b0;
      spurious_q  <= 1'b0;
      vs_q        <= 1'b0;
      hs_q        <= 1'b0;
      de_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      frames_q    <= frames_d;
      frame_cnt_q <= frame_cnt_d;
      x_q         <= x_d;
      y_q         <= y_d;
      drain_q     <= drain_d;
      ret_q       <= ret_d;
      pix_q       <= pix_d;
      hit_q       <= hit_d;
      fod_q       <= fod_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      timeout_q   <= timeout_d;
      spurious_q  <= spurious_d;
      vs_q        <= vs_d;
      hs_q        <= hs_d;
      de_q        <= de_d;
    end
  end

  assign busy           = busy_q;
  assign done           = done_q;
  assign timeout        = timeout_q;
  assign spurious       = spurious_q;
  assign vs_in          = vs_q;
  assign hs_in          = hs_q;
  assign de_in          = de_q;
  assign x_cnt          = x_q;
  assign y_cnt          = y_q;
  assign frame_out_done = fod_q;
  assign ret_count      = ret_q;

endmodule

// File: tb/tb_snn_frame_ctrl.sv
// Scoreboard bench for snn_frame_ctrl: a frame-level reference model queues
// the expected per-cycle outputs of each run; a monitor pops and compares.
module tb_snn_frame_ctrl;

  localparam int H = 8, V = 4, HB = 2, VB = 1, PD = 3;
  localparam int HT = H + HB, VT = V + VB, FL = HT * VT, FP = H * V, DL = 4 * PD;

  logic        clk = 1'b0, reset_n = 1'b0, start = 1'b0, de_ret = 1'b0;
  logic [7:0]  num_frames = 8'd0;
  logic        busy, done, timeout, spurious, vs_in, hs_in, de_in, frame_out_done;
  logic [9:0]  x_cnt, y_cnt;
  logic [27:0] ret_count;

  snn_frame_ctrl #(.H_RES(H), .V_RES(V), .H_BLANK(HB), .V_BLANK(VB), .PIPELINE_DELAY(PD)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .num_frames(num_frames),
    .busy(busy), .done(done), .timeout(timeout), .spurious(spurious),
    .vs_in(vs_in), .hs_in(hs_in), .de_in(de_in), .x_cnt(x_cnt), .y_cnt(y_cnt),
    .de_ret(de_ret), .frame_out_done(frame_out_done), .ret_count(ret_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic busy, done, timeout, spurious, vs, hs, de, fod;
    logic [9:0] x, y;
    logic [27:0] ret;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_a, mon_e;
  int   n_checks = 0, n_fail = 0;
  bit   mon_en = 1'b0;
  int   last_ret = 0;

  function automatic string fmt(input exp_t v);
    return $sformatf("busy=%0b done=%0b to=%0b sp=%0b vs=%0b hs=%0b de=%0b fod=%0b x=%0d y=%0d ret=%0d",
                     v.busy, v.done, v.timeout, v.spurious, v.vs, v.hs, v.de, v.fod, v.x, v.y, v.ret);
  endfunction

  function automatic exp_t sample();
    return {busy, done, timeout, spurious, vs_in, hs_in, de_in, frame_out_done, x_cnt, y_cnt, ret_count};
  endfunction

  always @(negedge clk) begin
    if (mon_en && (busy || done || frame_out_done)) begin
      mon_a = sample();
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_output: got %s, required no activity", fmt(mon_a));
      end else begin
        mon_e = exp_q.pop_front();
        if (mon_a !== mon_e) begin
          n_fail++;
          $display("FAIL cycle_outputs: got %s, required %s", fmt(mon_a), fmt(mon_e));
        end
      end
    end
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d", name, got, want);
    end
  endtask

  // mode 0: every pixel returns, 1: none return, 2: random drops.
  task automatic run(input int n, input int dly, input int mode);
    int   ret_at[];
    bit   hit[];
    int   a, total, cnt, exit_j, last_c, done_c, vis, ign_c, sz;
    bit   to, found, exp_sp;
    exp_t e;
    a = n * FL;
    total = n * FP;
    sz = a + dly + 40;
    ret_at = new[sz];
    hit = new[sz];
    for (int f = 0; f < n; f++)
      for (int yy = 0; yy < V; yy++)
        for (int xx = 0; xx < H; xx++)
          if (mode == 0 || (mode == 2 && $urandom_range(7) != 0))
            ret_at[f * FL + yy * HT + xx + dly] = 1;
    to = 1'b0;
    exp_sp = 1'b0;
    if (n == 0) begin
      e = '0;
      e.done = 1'b1;
      e.ret = 28'(last_ret);
      exp_q.push_back(e);
      done_c = 0;
    end else begin
      cnt = 0;
      for (int c = 0; c < a; c++) cnt += ret_at[c];
      found = 1'b0;
      exit_j = DL - 1;
      for (int j = 0; j < DL && !found; j++) begin
        cnt += ret_at[a + j];
        if (cnt == total) begin
          found = 1'b1;
          exit_j = j;
        end
      end
      to = !found;
      last_c = a + exit_j;
      done_c = last_c + 1;
      vis = 0;
      for (int c = 0; c <= done_c + 1; c++) begin
        e = '0;
        e.busy = (c < done_c);
        e.done = (c == done_c);
        e.timeout = to && (c >= done_c);
        if (c < a) begin
          e.x = 10'(c % HT);
          e.y = 10'((c / HT) % VT);
          e.vs = (e.y == 0);
          e.hs = (e.x < H);
          e.de = (e.x < H) && (e.y < V);
        end
        e.ret = 28'(vis);
        e.fod = (c >= 2) && hit[c - 2];
        if (c <= done_c || e.fod) exp_q.push_back(e);
        if (c <= last_c && ret_at[c] != 0) begin
          vis++;
          if (vis % FP == 0) hit[c] = 1'b1;
        end
      end
      last_ret = vis;
      for (int c = done_c + 1; c < sz; c++) if (ret_at[c] != 0) exp_sp = 1'b1;
    end
    ign_c = (n > 0 && $urandom_range(1) == 1) ? $urandom_range(a - 1, 1) : -1;
    @(posedge clk); #1;
    start = 1'b1;
    num_frames = 8'(n);
    de_ret = 1'b0;
    for (int c = 0; c <= done_c + 3; c++) begin
      @(posedge clk); #1;
      start = (c == ign_c);
      if (c == ign_c) num_frames = 8'($urandom);
      de_ret = ret_at[c] != 0;
    end
    @(posedge clk); #1;
    de_ret = 1'b0;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("queue_drained", 64'(exp_q.size()), 64'd0);
    check("spurious_after_run", 64'(spurious), 64'(exp_sp));
  endtask

  initial begin
    #1;
    check("reset_outputs", 64'(sample()), 64'd0);
    #22 reset_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("idle_busy_done", 64'({busy, done}), 64'd0);
    mon_en = 1'b1;

    run(1, 3, 0);
    run(2, 3, 0);
    run(1, 3, 1);
    run(1, 3, 0);
    run(0, 3, 0);

    @(posedge clk); #1 de_ret = 1'b1;
    @(posedge clk); #1 de_ret = 1'b0;
    @(negedge clk);
    check("spurious_set", 64'(spurious), 64'd1);

    run(1, 24, 0);
    run(1, 25, 0);
    run(2, 26, 0);
    for (int i = 0; i < 20; i++)
      run($urandom_range(3, 1), $urandom_range(26, 1), $urandom_range(2, 0));

    mon_en = 1'b0;
    exp_q.delete();
    @(posedge clk); #1;
    start = 1'b1;
    num_frames = 8'd2;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (37) @(posedge clk);
    #3 reset_n = 1'b0;
    #1 check("reset_mid_frame", 64'(sample()), 64'd0);
    repeat (2) @(posedge clk);
    #2 reset_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("post_reset_idle", 64'({busy, done}), 64'd0);
    end
    last_ret = 0;
    mon_en = 1'b1;
    run(1, 3, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
